imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes the words sequentially into instruction memory from word address 0.
- Holds the core stopped (Core_Run=0) until an end-of-program sentinel word has been written, then releases it.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity = 2**ADDR_W words
EOF_WORD, 32'hFFFF_FFFF, end-of-program sentinel word; written to memory, then load completes

Ports:
Clock  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous active-low reset
Start  in  1  single-cycle pulse; begins a new load
Byte_In  in  8  stream byte
Byte_Valid  in  1  Byte_In is valid
Byte_Ready  out  1  loader accepts a byte this cycle
Imem_Write  out  1  instruction-memory write strobe, one cycle per word
Imem_Addr  out  ADDR_W  word address for the write
Imem_Data  out  32  word to write
Word_Count  out  ADDR_W+1  words written in the current load, sentinel included
Busy  out  1  high in RECV or WRITE
Core_Run  out  1  high only in DONE; gates the core's PC and register-file clock enables
Error  out  1  high only in ERR

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE.
  - All outputs 0; byte counter, shift register and Word_Count cleared.
  - Asserting Reset_n mid-load aborts the load; no partial write is issued.
- FSM states: IDLE, RECV, WRITE, DONE, ERR. Outputs are Moore-decoded from state or from registers; no combinational path from inputs to outputs.
- IDLE:
  - Byte_Ready=0.
  - Start -> RECV; clear byte counter and Word_Count.
- RECV:
  - Byte_Ready=1.
  - Transfer occurs when Byte_Valid & Byte_Ready at the clock edge.
  - On each transfer: word <= {word[23:0], Byte_In}; byte counter increments (2-bit).
  - On the 4th transfer -> WRITE.
  - Byte_Valid gaps are allowed; no timeout.
- WRITE (exactly one cycle):
  - Byte_Ready=0; Imem_Write=1; Imem_Addr=Word_Count[ADDR_W-1:0]; Imem_Data=assembled word.
  - Word_Count increments at the end of the cycle.
  - Next state:
    - word==EOF_WORD -> DONE.
    - else if Imem_Addr==2**ADDR_W-1 (no room left for the sentinel) -> ERR.
    - else -> RECV.
- Latency: Imem_Write is high in the cycle immediately after the 4th byte is accepted.
- Peak throughput: one word per 5 cycles.
- DONE:
  - Core_Run=1, held indefinitely; Byte_Ready=0.
  - Start -> RECV with counters cleared; Core_Run drops in the same edge.
- ERR:
  - Error=1, Core_Run=0, Byte_Ready=0.
  - Start -> RECV with counters cleared; Error clears.
- Start in RECV or WRITE is ignored; the load in progress continues unchanged.
- Sentinel at address 0 (empty program) is legal: DONE with Word_Count=1.
- Byte_Valid while Byte_Ready=0 is not consumed; the source must hold the byte.
- Word_Count saturates by construction; its maximum is 2**ADDR_W.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RECV, WRITE, DONE, ERR) with 3-bit encoding;
  - default EOF_WORD constant, shared with the core's end-of-program detection.
- One sub-module, byte_packer: 8-to-32 big-endian shift register plus 2-bit byte counter, with clear and shift-enable inputs and a word_full flag.
- The FSM, address counter and status outputs stay in the top.

Test Plan:
- Normal load:
  - Stimulus: Start, then bytes 12 34 56 78, AA BB CC DD, FF FF FF FF, Byte_Valid held high.
  - Response: writes 0x12345678@0, 0xAABBCCDD@1, 0xFFFFFFFF@2; each Imem_Write is 1 cycle, 5 cycles apart; Word_Count=3; Core_Run=1.
- Handshake gaps:
  - Stimulus: same bytes, with Byte_Valid low 3 cycles between every byte.
  - Response: identical memory contents; no byte is lost or duplicated; Byte_Ready=0 during every WRITE cycle.
- Overflow (ADDR_W=2):
  - Stimulus: 4 non-sentinel words.
  - Response: writes at addresses 0..3, then Error=1, Core_Run=0, Word_Count=4.
  - Follow-up: Start then sentinel only -> DONE with Word_Count=1.
- Reset mid-load:
  - Stimulus: Reset_n low after 2 bytes of word 1.
  - Response: all outputs 0 immediately; no Imem_Write issued.
  - Follow-up: a fresh Start with a full stream loads from address 0.
- Start robustness:
  - Stimulus: Start pulsed while in RECV, then again in DONE.
  - Response: the first pulse is ignored (addresses stay contiguous); the second drops Core_Run the next cycle and reload begins at address 0.
- Empty program:
  - Stimulus: Start, then FF FF FF FF.
  - Response: a single write of 0xFFFFFFFF@0; DONE; Word_Count=1.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the core's
// end-of-program detection.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    localparam logic [31:0] DEFAULT_EOF_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian 8-to-32 packer: each accepted byte shifts in at the LSB end, so
// the first byte of a word lands in bits [31:24].
module imem_boot_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (shift_en_i) begin
            word_d = {word_q[23:0], byte_i};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    // Flags the shift that completes a word; the counter wraps to 0 on it.
    assign word_full_o = shift_en_i && (cnt_q == 2'd3);
    assign word_o      = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a byte stream into words, writes them to instruction
// memory from address 0 and releases the core once the sentinel is stored.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] EOF_WORD = DEFAULT_EOF_WORD
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Imem_Write,
    output logic [ADDR_W-1:0] Imem_Addr,
    output logic [31:0]       Imem_Data,
    output logic [ADDR_W:0]   Word_Count,
    output logic              Busy,
    output logic              Core_Run,
    output logic              Error
);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              packer_clear;
    logic              shift_en;
    logic              word_full;
    logic [31:0]       word;
    logic              last_addr;

    imem_boot_loader_byte_packer u_packer (
        .clk         (Clock),
        .rst_n       (Reset_n),
        .clear_i     (packer_clear),
        .shift_en_i  (shift_en),
        .byte_i      (Byte_In),
        .word_o      (word),
        .word_full_o (word_full)
    );

    assign last_addr = &word_count_q[ADDR_W-1:0];

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        packer_clear = 1'b0;
        shift_en     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (Start) begin
                    state_d      = ST_RECV;
                    packer_clear = 1'b1;
                    word_count_d = '0;
                end
            end
            ST_RECV: begin
                shift_en = Byte_Valid;
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                word_count_d = word_count_q + (ADDR_W+1)'(1);
                // Sentinel wins over a full memory: it may occupy the last slot.
                if (word == EOF_WORD)  state_d = ST_DONE;
                else if (last_addr)    state_d = ST_ERR;
                else                   state_d = ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

    assign Byte_Ready = (state_q == ST_RECV);
    assign Imem_Write = (state_q == ST_WRITE);
    assign Imem_Addr  = word_count_q[ADDR_W-1:0];
    assign Imem_Data  = word;
    assign Word_Count = word_count_q;
    assign Busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign Core_Run   = (state_q == ST_DONE);
    assign Error      = (state_q == ST_ERR);

endmodule
